ram_block_copier: RTL and testbench



---
 rtl/ram_copy_pkg.sv | 8 +
 rtl/ram_copy_addr_gen.sv | 57 +++++
 rtl/ram_block_copier.sv | 142 ++++++++++++++
 tb/tb_ram_block_copier.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_copy_pkg.sv
// Shared types and defaults for the RAM block copier.
package ram_copy_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int RAM_DEPTH  = 2 ** DEF_ADDR_W;

  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;
endpackage

// File: rtl/ram_copy_addr_gen.sv
// Source/destination address steppers for the block copier; the copy
// direction is chosen at load time so overlapping moves stay correct.
module ram_copy_addr_gen
  import ram_copy_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_src,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic [ADDR_W:0]   i_len,
  output logic [ADDR_W-1:0] o_cur_src,
  output logic [ADDR_W-1:0] o_cur_dst,
  output logic              o_last
);
  localparam logic [ADDR_W-1:0] A_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W:0]   r_rem;
  logic              r_desc;

  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_span;
  logic              w_desc;

  // Destination ahead of source inside the block: copy from the top down.
  assign w_off  = i_dst - i_src;
  assign w_span = ADDR_W'(i_len - LEN_ONE);
  assign w_desc = (w_off != '0) && ({1'b0, w_off} < i_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_rem  <= '0;
      r_desc <= 1'b0;
    end else if (i_load) begin
      r_desc <= w_desc;
      r_rem  <= i_len;
      r_src  <= w_desc ? i_src + w_span : i_src;
      r_dst  <= w_desc ? i_dst + w_span : i_dst;
    end else if (i_step) begin
      r_src <= r_desc ? r_src - A_ONE : r_src + A_ONE;
      r_dst <= r_desc ? r_dst - A_ONE : r_dst + A_ONE;
      r_rem <= r_rem - LEN_ONE;
    end
  end

  assign o_cur_src = r_src;
  assign o_cur_dst = r_dst;
  assign o_last    = (r_rem == LEN_ONE);
endmodule

// File: rtl/ram_block_copier.sv
// Overlap-safe block copy engine for a dual-port RAM, one word per clock.
// Optional XOR checksum of copied words enabled by RAM_COPY_CHECKSUM_EN.
module ram_block_copier
  import ram_copy_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] ram_addr_rd,
  input  logic [DATA_W-1:0] ram_dout_rd,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr_wr,
  output logic [DATA_W-1:0] ram_din_wr,
  output logic [DATA_W-1:0] checksum
);
  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t r_state;
  logic   r_busy;
  logic   r_done;
  logic   r_err;
  logic   r_we;

  logic w_req;
  logic w_bad;
  logic w_trivial;
  logic w_accept;
  logic w_load;
  logic w_step;
  logic w_last;
  logic [ADDR_W-1:0] w_cur_src;
  logic [ADDR_W-1:0] w_cur_dst;

  assign w_req     = (r_state == IDLE) && start;
  assign w_bad     = (len > LEN_MAX);
  assign w_trivial = (len == '0) || (src_addr == dst_addr);
  assign w_accept  = w_req && !w_bad;
  assign w_load    = w_accept && !w_trivial;
  assign w_step    = (r_state == COPY);

  ram_copy_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_src     (src_addr),
    .i_dst     (dst_addr),
    .i_len     (len),
    .o_cur_src (w_cur_src),
    .o_cur_dst (w_cur_dst),
    .o_last    (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          r_we   <= 1'b0;
          r_busy <= 1'b0;
          if (start) begin
            if (w_bad) begin
              r_err <= 1'b1;
            end else if (w_trivial) begin
              r_state <= DONE;
              r_busy  <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_state <= COPY;
              r_busy  <= 1'b1;
              r_we    <= 1'b1;
            end
          end
        end
        COPY: begin
          if (w_last) begin
            r_state <= DONE;
            r_we    <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

`ifdef RAM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= '0;
    end else if (w_step) begin
      r_checksum <= r_checksum ^ ram_dout_rd;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign ram_we      = r_we;
  assign ram_addr_rd = w_cur_src;
  assign ram_addr_wr = w_cur_dst;
  // Read data goes straight to the write port in the same cycle.
  assign ram_din_wr  = ram_dout_rd;
endmodule

// File: tb/tb_ram_block_copier.sv
// Bench for ram_block_copier with a behavioural 16x8 dual-port RAM target.
module tb_ram_block_copier;
  import ram_copy_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] src_addr;
  logic [3:0] dst_addr;
  logic [4:0] len;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] ram_addr_rd;
  logic [7:0] ram_dout_rd;
  logic       ram_we;
  logic [3:0] ram_addr_wr;
  logic [7:0] ram_din_wr;
  logic [7:0] checksum;

  logic [7:0] ram [RAM_DEPTH];
  logic       tb_we;
  logic [3:0] tb_addr;
  logic [7:0] tb_data;

  int n_chk;
  int n_pass;

  ram_block_copier #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .ram_addr_rd (ram_addr_rd),
    .ram_dout_rd (ram_dout_rd),
    .ram_we      (ram_we),
    .ram_addr_wr (ram_addr_wr),
    .ram_din_wr  (ram_din_wr),
    .checksum    (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Target RAM: async read, sync write; the bench port preloads contents.
  assign ram_dout_rd = ram[ram_addr_rd];
  always_ff @(posedge clk) begin
    if (tb_we) ram[tb_addr] <= tb_data;
    else if (ram_we) ram[ram_addr_wr] <= ram_din_wr;
  end

  typedef struct {
    logic [3:0] src;
    logic [3:0] dst;
    logic [4:0] len;
    logic [7:0] seed;
    int         exp_we;
    int         exp_done_cyc;
    int         exp_err;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic fill(input logic [7:0] seed);
    for (int i = 0; i < RAM_DEPTH; i++) wr(4'(i), 8'(i * 17) ^ seed);
  endtask

  // Pulse start for one accept edge, then observe a fixed window of cycles.
  task automatic run_op(input logic [3:0] s, input logic [3:0] d, input logic [4:0] l,
                        output int we_c, output int done_c, output int done_cyc,
                        output int err_c, output int busy_c);
    we_c = 0; done_c = 0; done_cyc = 0; err_c = 0; busy_c = 0;
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      if (ram_we) we_c++;
      if (busy) busy_c++;
      if (err) err_c++;
      if (done) begin
        done_c++;
        if (done_cyc == 0) done_cyc = c;
      end
      @(negedge clk);
    end
  endtask

  vec_t       vecs [11];
  logic [7:0] snap [RAM_DEPTH];
  logic [7:0] expm [RAM_DEPTH];
  logic [7:0] tmp  [RAM_DEPTH];
  logic [7:0] exp_cks;
  logic [7:0] xr;
  logic [3:0] a;
  int we_c, done_c, done_cyc, err_c, busy_c, bad;

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    exp_cks = 8'h00;

    vecs[0]  = '{4'd2,  4'd8,  5'd3,  8'h5A, 3, 4, 0};
    vecs[1]  = '{4'd0,  4'd1,  5'd4,  8'h33, 4, 5, 0};
    vecs[2]  = '{4'd14, 4'd5,  5'd3,  8'hC1, 3, 4, 0};
    vecs[3]  = '{4'd4,  4'd9,  5'd0,  8'h0F, 0, 1, 0};
    vecs[4]  = '{4'd6,  4'd6,  5'd5,  8'h71, 0, 1, 0};
    vecs[5]  = '{4'd1,  4'd2,  5'd17, 8'h92, 0, 0, 1};
    vecs[6]  = '{4'd15, 4'd1,  5'd4,  8'h48, 4, 5, 0};
    vecs[7]  = '{4'd4,  4'd2,  5'd5,  8'hE6, 5, 6, 0};
    vecs[8]  = '{4'd7,  4'd7,  5'd16, 8'h2B, 0, 1, 0};
    vecs[9]  = '{4'd9,  4'd3,  5'd1,  8'hB4, 1, 2, 0};
    vecs[10] = '{4'd3,  4'd3,  5'd31, 8'h6D, 0, 0, 1};

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr_rd", ram_addr_rd, 0);
    chk("rst_addr_wr", ram_addr_wr, 0);
    chk("rst_cks", checksum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 11; v++) begin
      fill(vecs[v].seed);
      for (int i = 0; i < RAM_DEPTH; i++) begin snap[i] = ram[i]; expm[i] = ram[i]; end
      xr = 8'h00;
      if (vecs[v].exp_err == 0 && vecs[v].len != 0 && vecs[v].src != vecs[v].dst) begin
        for (int j = 0; j < int'(vecs[v].len); j++) begin
          a = vecs[v].src + 4'(j);
          tmp[j] = snap[a];
          xr = xr ^ snap[a];
        end
        for (int j = 0; j < int'(vecs[v].len); j++) begin
          a = vecs[v].dst + 4'(j);
          expm[a] = tmp[j];
        end
      end
`ifdef RAM_COPY_CHECKSUM_EN
      if (vecs[v].exp_err == 0) exp_cks = xr;
`endif
      run_op(vecs[v].src, vecs[v].dst, vecs[v].len, we_c, done_c, done_cyc, err_c, busy_c);
      bad = 0;
      for (int i = 0; i < RAM_DEPTH; i++) if (ram[i] !== expm[i]) bad++;
      chk($sformatf("v%0d_we_cycles", v), we_c, vecs[v].exp_we);
      chk($sformatf("v%0d_done_cycle", v), done_cyc, vecs[v].exp_done_cyc);
      chk($sformatf("v%0d_done_pulses", v), done_c, (vecs[v].exp_err != 0) ? 0 : 1);
      chk($sformatf("v%0d_err_pulses", v), err_c, vecs[v].exp_err);
      chk($sformatf("v%0d_busy_cycles", v), busy_c, vecs[v].exp_done_cyc);
      chk($sformatf("v%0d_ram_bad_words", v), bad, 0);
      chk($sformatf("v%0d_checksum", v), checksum, exp_cks);
    end

    // Hand sequence: basic copy with hand-computed data and port values.
    for (int i = 0; i < RAM_DEPTH; i++) wr(4'(i), 8'h00);
    wr(4'd2, 8'hAA); wr(4'd3, 8'hBB); wr(4'd4, 8'hCC);
    src_addr = 4'd2; dst_addr = 4'd8; len = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("basic_c1_addr_rd", ram_addr_rd, 4'd2);
    chk("basic_c1_addr_wr", ram_addr_wr, 4'd8);
    chk("basic_c1_din", ram_din_wr, 8'hAA);
    chk("basic_c1_we", ram_we, 1);
    repeat (3) @(negedge clk);
    chk("basic_c4_done", done, 1);
    chk("basic_c4_we", ram_we, 0);
    @(negedge clk);
    chk("basic_c5_done", done, 0);
    chk("basic_c5_busy", busy, 0);
    chk("basic_ram8", ram[8], 8'hAA);
    chk("basic_ram9", ram[9], 8'hBB);
    chk("basic_ram10", ram[10], 8'hCC);
    chk("basic_ram11", ram[11], 8'h00);
`ifdef RAM_COPY_CHECKSUM_EN
    chk("basic_checksum", checksum, 8'hDD);
`else
    chk("basic_checksum", checksum, 8'h00);
`endif

    // Hand sequence: reset after three writes of an eight-word copy.
    fill(8'h3C);
    for (int i = 0; i < RAM_DEPTH; i++) snap[i] = ram[i];
    src_addr = 4'd0; dst_addr = 4'd8; len = 5'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", ram_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr_wr", ram_addr_wr, 0);
    chk("midrst_cks", checksum, 0);
    @(negedge clk);
    @(negedge clk);
    bad = 0;
    for (int i = 8; i < 16; i++) if (ram[i] !== snap[i]) bad++;
    chk("midrst_words_changed", bad, 3);
    chk("midrst_ram8", ram[8], snap[0]);
    chk("midrst_ram10", ram[10], snap[2]);
    chk("midrst_ram11", ram[11], snap[11]);
    rst_n = 1'b1;
    @(negedge clk);

    // Hand sequence: new start with different inputs during a copy.
    fill(8'hA5);
    for (int i = 0; i < RAM_DEPTH; i++) snap[i] = ram[i];
    src_addr = 4'd0; dst_addr = 4'd8; len = 5'd6; start = 1'b1;
    @(negedge clk);
    we_c = 0; done_c = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c >= 2 && c <= 4) begin
        start = 1'b1; src_addr = 4'd5; dst_addr = 4'd12; len = 5'd2;
      end else begin
        start = 1'b0;
      end
      if (ram_we) we_c++;
      if (done) done_c++;
      @(negedge clk);
    end
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) if (ram[8 + i] !== snap[i]) bad++;
    for (int i = 14; i < 16; i++) if (ram[i] !== snap[i]) bad++;
    chk("busy_start_we_cycles", we_c, 6);
    chk("busy_start_done_pulses", done_c, 1);
    chk("busy_start_bad_words", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
